rr_encoder4x2: RTL and testbench



---
 rtl/rr_encoder_pkg.sv | 22 ++
 rtl/pri_encoder4x2.sv | 47 ++++
 rtl/rr_encoder4x2.sv | 95 +++++++++
 tb/tb_rr_encoder4x2.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rr_encoder_pkg.sv
// rtl/rr_encoder_pkg.sv - shared constants and types for the round-robin 4:2 encoder
//
// Purpose: single source for requester count, index width, the vector/index
// typedefs and a one-hot helper used by the encoder and its priority stage.
// Ports: none (package).
package rr_encoder_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  // One-hot vector with only bit `idx` set.
  function automatic req_vec_t onehot(input idx_t idx);
    req_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pri_encoder4x2.sv
// rtl/pri_encoder4x2.sv - rotating-priority 4:2 encoder (combinational)
//
// Purpose: pick the first pending requester starting at the priority pointer
// and wrapping upward, and report its index.
// Ports:
//   req_i  request vector, bit i set means requester i is pending
//   ptr_i  highest-priority requester index
//   sel_o  index of the selected requester (don't-care when any_o=0)
//   any_o  at least one request is pending
module pri_encoder4x2
  import rr_encoder_pkg::*;
(
  input  req_vec_t req_i,
  input  idx_t     ptr_i,
  output idx_t     sel_o,
  output logic     any_o
);

  // Rotated view: rot[k] is requester (ptr + k) mod 4, so rot[0] is the
  // highest-priority slot and a plain lowest-bit search gives the winner.
  req_vec_t rot;
  idx_t     off;

  always_comb begin
    rot = req_i;
    unique case (ptr_i)
      2'd0: rot = req_i;
      2'd1: rot = {req_i[0],   req_i[3:1]};
      2'd2: rot = {req_i[1:0], req_i[3:2]};
      2'd3: rot = {req_i[2:0], req_i[3]};
      default: rot = req_i;
    endcase
  end

  // Scan from the top down so the lowest set offset is the one that sticks.
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = idx_t'(k);
    end
  end

  // Rotate back: offset is relative to ptr, modulo-4 add restores the index.
  assign sel_o = ptr_i + off;
  assign any_o = |req_i;

endmodule

// File: rtl/rr_encoder4x2.sv
// rtl/rr_encoder4x2.sv - registered round-robin 4:2 encoder with valid/ready output
//
// Purpose: fairly select one of four requesters, grant it (one-hot,
// combinational) and present its 2-bit index on a registered valid/ready port.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        request vector; requesters hold until they see their grant bit
//   out_ready  downstream accepts out_idx this cycle
//   out_valid  out_idx holds a valid selection
//   out_idx    encoded index of the granted requester
//   grant      one-hot grant, high in the cycle the request is captured
//   ptr        current round-robin priority pointer
module rr_encoder4x2
  import rr_encoder_pkg::*;
#(
  parameter int N_REQ_P = N_REQ,
  parameter int IDX_W_P = IDX_W
) (
  input  logic     clk,
  input  logic     reset,
  input  req_vec_t req,
  input  logic     out_ready,
  output logic     out_valid,
  output idx_t     out_idx,
  output req_vec_t grant,
  output idx_t     ptr
);

  // The datapath is hard-wired for four requesters; catch a wrong override.
  if (N_REQ_P != 4 || IDX_W_P != 2) begin : g_param_check
    $error("rr_encoder4x2 supports only N_REQ=4, IDX_W=2");
  end

  logic out_valid_q, out_valid_d;
  idx_t out_idx_q,   out_idx_d;
  idx_t ptr_q,       ptr_d;

  idx_t sel;
  logic any;
  logic load_en;

  pri_encoder4x2 u_pri (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (sel),
    .any_o (any)
  );

  // Output register is empty or being drained this cycle. Selection is made
  // from the live req, so a stall never leaves a stale choice behind.
  assign load_en = !reset && (!out_valid_q || out_ready);

  always_comb begin
    grant       = '0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any) begin
        grant       = onehot(sel);
        out_valid_d = 1'b1;
        out_idx_d   = sel;
        ptr_d       = sel + 2'd1;
      end else begin
        // Nothing to capture: drop valid, keep the last index and pointer.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign ptr       = ptr_q;

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant));

  a_grant_needs_load : assert property (@(posedge clk) (grant != '0) |-> load_en);

  a_idx_stable_stall : assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !out_ready) |=> $stable(out_idx_q));

endmodule

// File: tb/tb_rr_encoder4x2.sv
// tb/tb_rr_encoder4x2.sv - directed self-checking bench for rr_encoder4x2
module tb_rr_encoder4x2;
  import rr_encoder_pkg::*;

  logic     clk;
  logic     reset;
  req_vec_t req;
  logic     out_ready;
  logic     out_valid;
  idx_t     out_idx;
  req_vec_t grant;
  idx_t     ptr;

  int checks;
  int failures;

  rr_encoder4x2 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .grant     (grant),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
    checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", grant); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || ptr !== 2'd1) begin
      failures++; $display("FAIL reset_first_capture got v=%b idx=%0d ptr=%0d exp v=1 idx=0 ptr=1", out_valid, out_idx, ptr);
    end
  endtask

  task automatic test_round_robin();
    req_vec_t exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    idx_t     exp_i [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    idx_t     exp_p [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    req = 4'b1111; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (grant !== exp_g[n]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", n, grant, exp_g[n]); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== exp_i[n] || ptr !== exp_p[n]) begin
        failures++; $display("FAIL rr_capture[%0d] got v=%b idx=%0d ptr=%0d exp v=1 idx=%0d ptr=%0d", n, out_valid, out_idx, ptr, exp_i[n], exp_p[n]);
      end
    end
  endtask

  task automatic test_skip();
    // ptr=1 here; take requester 1 to move ptr to 2.
    req = 4'b0010; #1; tick();
    checks++; if (ptr !== 2'd2 || out_idx !== 2'd1) begin failures++; $display("FAIL skip_setup got idx=%0d ptr=%0d exp idx=1 ptr=2", out_idx, ptr); end
    req = 4'b0011; #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL skip_grant got=%b exp=0001", grant); end
    tick();
    checks++; if (out_idx !== 2'd0 || ptr !== 2'd1) begin failures++; $display("FAIL skip_wrap got idx=%0d ptr=%0d exp idx=0 ptr=1", out_idx, ptr); end
    #1;
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL skip_next_grant got=%b exp=0010", grant); end
    tick();
    checks++; if (out_idx !== 2'd1 || ptr !== 2'd2) begin failures++; $display("FAIL skip_next got idx=%0d ptr=%0d exp idx=1 ptr=2", out_idx, ptr); end
  endtask

  task automatic test_backpressure();
    req = 4'b0100; out_ready = 1'b1; #1; tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2 || ptr !== 2'd3) begin
      failures++; $display("FAIL bp_setup got v=%b idx=%0d ptr=%0d exp v=1 idx=2 ptr=3", out_valid, out_idx, ptr);
    end
    out_ready = 1'b0; req = 4'b1000;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL bp_grant[%0d] got=%b exp=0000", n, grant); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2 || ptr !== 2'd3) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b idx=%0d ptr=%0d exp v=1 idx=2 ptr=3", n, out_valid, out_idx, ptr);
      end
    end
    out_ready = 1'b1; #1;
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL bp_release_grant got=%b exp=1000", grant); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd3 || ptr !== 2'd0) begin
      failures++; $display("FAIL bp_release got v=%b idx=%0d ptr=%0d exp v=1 idx=3 ptr=0", out_valid, out_idx, ptr);
    end
  endtask

  task automatic test_empty();
    req = 4'b0000; out_ready = 1'b1; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL empty_grant got=%b exp=0000", grant); end
    tick();
    checks++; if (out_valid !== 1'b0 || ptr !== 2'd0 || out_idx !== 2'd3) begin
      failures++; $display("FAIL empty_drain got v=%b idx=%0d ptr=%0d exp v=0 idx=3 ptr=0", out_valid, out_idx, ptr);
    end
  endtask

  task automatic test_single_requester();
    req = 4'b0100; out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant[%0d] got=%b exp=0100", n, grant); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2 || ptr !== 2'd3) begin
        failures++; $display("FAIL single_capture[%0d] got v=%b idx=%0d ptr=%0d exp v=1 idx=2 ptr=3", n, out_valid, out_idx, ptr);
      end
    end
  endtask

  task automatic test_stall_reselect();
    // Stalled with ptr=3; req changes before release and the live value wins.
    out_ready = 1'b0; req = 4'b0001; #1; tick();
    req = 4'b0010; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reselect_stall_grant got=%b exp=0000", grant); end
    tick();
    out_ready = 1'b1; #1;
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL reselect_grant got=%b exp=0010", grant); end
    tick();
    checks++; if (out_idx !== 2'd1 || ptr !== 2'd2) begin failures++; $display("FAIL reselect_capture got idx=%0d ptr=%0d exp idx=1 ptr=2", out_idx, ptr); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; req = 4'b1111; #1; tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_stall_setup got v=%b exp=1", out_valid); end
    reset = 1'b1; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_stall_grant got=%b exp=0000", grant); end
    out_ready = 1'b1; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_ready_grant got=%b exp=0000", grant); end
    tick();
    checks++; if (out_valid !== 1'b0 || ptr !== 2'd0 || out_idx !== 2'd0) begin
      failures++; $display("FAIL rst_stall_clear got v=%b idx=%0d ptr=%0d exp v=0 idx=0 ptr=0", out_valid, out_idx, ptr);
    end
    reset = 1'b0; #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rst_resume_grant got=%b exp=0001", grant); end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; req = '0; out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_empty();
    test_single_requester();
    test_stall_reselect();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
